// File: rtl/shim_ads816x_adc_timing_calc.sv
// Purpose : minimum ADS816x n_cs high time (SPI cycles) from the SPI clock frequency, via ceiling divides.
// Latency : 132 cycles from the calc sampling edge to done with SHIM_ADC_TIMING_CYCLE_CHECK_EN defined, 67 without.
// Backpres: level handshake; calc held keeps done/result valid, frequency change while held raises lock_viol.
module shim_ads816x_adc_timing_calc #(
    parameter int unsigned T_CONV_NS       = 660,
    parameter int unsigned T_CYCLE_NS      = 1000,
    parameter int unsigned SPI_CMD_BITS    = 16,
    parameter int unsigned MIN_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] spi_clk_freq_hz,
    input  logic        calc,
    output logic [7:0]  n_cs_high_time,
    output logic        done,
    output logic        lock_viol
);

    // The cycle-time gap term is optional; without it only conversion time and the floor apply.
`ifdef SHIM_ADC_TIMING_CYCLE_CHECK_EN
    localparam bit CYCLE_CHECK = 1'b1;
`else
    localparam bit CYCLE_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_CONV,
        ST_DIV_CYCLE,
        ST_RESULT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [31:0] CONV_NS   = 32'(T_CONV_NS);
    localparam logic [31:0] CYCLE_NS  = 32'(T_CYCLE_NS);
    localparam logic [63:0] ROUND_UP  = 64'd999_999_999;
    localparam logic [31:0] NS_PER_S  = 32'd1_000_000_000;
    localparam logic [31:0] CMD_BITS  = 32'(SPI_CMD_BITS);
    localparam logic [31:0] MIN_CYC   = 32'(MIN_HIGH_CYCLES);
    localparam logic [6:0]  DIV_ITERS = 7'd64;

    state_t      state;
    logic [31:0] f_lat;        // frequency latched when calc was sampled
    logic [63:0] dvd;          // dividend, shifted left one bit per iteration
    logic [30:0] rem;          // remainder; always < 1e9 so 31 bits hold it exactly
    logic [31:0] quo;          // low quotient bits; the upper 32 are provably zero
    logic [6:0]  cnt;          // iteration count within the current division
    logic [31:0] c_conv;
    logic [31:0] c_gap;
    logic [31:0] final_cyc;

    logic [31:0] mul_ns;
    logic [31:0] mul_f;
    logic [63:0] dvd_load;
    logic [31:0] r_shift;
    logic        r_ge;
    logic [30:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] gap_calc;
    logic [31:0] final_calc;
    logic [7:0]  result_sat;
    logic        freq_moved;

    // Dividend for the next ceiling divide: conversion term from the live input while idle,
    // cycle term from the latched frequency once the first divide is finished.
    always_comb begin
        mul_ns = CYCLE_NS;
        mul_f  = f_lat;
        if (state == ST_IDLE) begin
            mul_ns = CONV_NS;
            mul_f  = spi_clk_freq_hz;
        end
        dvd_load = ({32'd0, mul_ns} * {32'd0, mul_f}) + ROUND_UP;
    end

    // One restoring shift-subtract step; the compare uses the shifted remainder.
    always_comb begin
        r_shift  = {rem, dvd[63]};
        r_ge     = (r_shift >= NS_PER_S);
        rem_next = r_ge ? 31'(r_shift - NS_PER_S) : r_shift[30:0];
        quo_next = {quo[30:0], r_ge};
    end

    // Gap term, max-of-three and 8-bit saturation.
    always_comb begin
        gap_calc   = (quo > CMD_BITS) ? (quo - CMD_BITS) : 32'd0;
        final_calc = c_conv;
        if (c_gap > final_calc) begin
            final_calc = c_gap;
        end
        if (MIN_CYC > final_calc) begin
            final_calc = MIN_CYC;
        end
        result_sat = (final_cyc > 32'd255) ? 8'd255 : final_cyc[7:0];
        freq_moved = (spi_clk_freq_hz != f_lat);
    end

    // Control FSM with registered outputs; frequency-lock abort beats calc release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            f_lat          <= '0;
            dvd            <= '0;
            rem            <= '0;
            quo            <= '0;
            cnt            <= '0;
            c_conv         <= '0;
            c_gap          <= '0;
            final_cyc      <= '0;
            n_cs_high_time <= '0;
            done           <= 1'b0;
            lock_viol      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    lock_viol <= 1'b0;
                    if (calc) begin
                        f_lat <= spi_clk_freq_hz;
                        dvd   <= dvd_load;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= '0;
                        c_gap <= '0;
                        state <= ST_DIV_CONV;
                    end
                end

                ST_ERROR: begin
                    done <= 1'b0;
                    if (!calc) begin
                        lock_viol <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    if (freq_moved) begin
                        lock_viol <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_ERROR;
                    end else if (!calc) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        case (state)
                            ST_DIV_CONV: begin
                                if (cnt != DIV_ITERS) begin
                                    dvd <= {dvd[62:0], 1'b0};
                                    rem <= rem_next;
                                    quo <= quo_next;
                                    cnt <= cnt + 7'd1;
                                end else begin
                                    c_conv <= quo;
                                    dvd    <= dvd_load;
                                    rem    <= '0;
                                    quo    <= '0;
                                    cnt    <= '0;
                                    state  <= CYCLE_CHECK ? ST_DIV_CYCLE : ST_RESULT;
                                end
                            end
                            ST_DIV_CYCLE: begin
                                if (cnt != DIV_ITERS) begin
                                    dvd <= {dvd[62:0], 1'b0};
                                    rem <= rem_next;
                                    quo <= quo_next;
                                    cnt <= cnt + 7'd1;
                                end else begin
                                    c_gap <= gap_calc;
                                    state <= ST_RESULT;
                                end
                            end
                            ST_RESULT: begin
                                final_cyc <= final_calc;
                                state     <= ST_DONE;
                            end
                            ST_DONE: begin
                                done           <= 1'b1;
                                n_cs_high_time <= result_sat;
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // A valid result and a lock violation are mutually exclusive.
    done_lock_excl: assert property (@(posedge clk) disable iff (!resetn) !(done && lock_viol));

endmodule
